// File: rtl/sipo_msb_rx_if.sv
// Parallel-side and serial-side signal bundle for the MSB-first SIPO receiver.
// The master modport drives the serial line and consumes words; slave is the receiver.
interface sipo_msb_rx_if #(
   parameter int DW = 4
);
   logic          enb;
   logic          start;
   logic          inp;
   logic          out_ready;
   logic          err_clr;
   logic [DW-1:0] out;
   logic          out_valid;
   logic          busy;
   logic          frame_err;
   logic          overrun;

   modport master (
      output enb, start, inp, out_ready, err_clr,
      input  out, out_valid, busy, frame_err, overrun
   );

   modport slave (
      input  enb, start, inp, out_ready, err_clr,
      output out, out_valid, busy, frame_err, overrun
   );
endinterface

// File: rtl/sipo_msb_rx.sv
// Serial-in parallel-out receiver: assembles DW bits (MSB first, framed by start)
// into a word offered on a valid/ready handshake, with sticky framing/overrun flags.
module sipo_msb_rx #(
   parameter int DW = 4
) (
   input  logic          clk,
   input  logic          rst,
   sipo_msb_rx_if.slave  bus
);
   localparam int CW = $clog2(DW + 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t        state_q,     state_d;
   logic [DW-1:0] shift_q,     shift_d;
   logic [CW-1:0] count_q,     count_d;
   logic [DW-1:0] out_q,       out_d;
   logic          out_valid_q, out_valid_d;
   logic          frame_err_q, frame_err_d;
   logic          overrun_q,   overrun_d;

   logic          done;
   logic          frame_err_set;
   logic          overrun_set;
   logic [DW-1:0] shifted;

   assign shifted = {shift_q[DW-2:0], bus.inp};

   always_comb begin
      // NOTE: every variable gets a default first so no path can infer a latch.
      state_d       = state_q;
      shift_d       = shift_q;
      count_d       = count_q;
      out_d         = out_q;
      out_valid_d   = out_valid_q;
      done          = 1'b0;
      frame_err_set = 1'b0;
      overrun_set   = 1'b0;

      if (bus.enb) begin
         if (bus.start) begin
            // A start inside a frame discards the partial word and restarts on this MSB.
            frame_err_set = (state_q == SHIFT);
            shift_d       = {{(DW-1){1'b0}}, bus.inp};
            count_d       = CW'(1);
            state_d       = SHIFT;
         end else if (state_q == SHIFT) begin
            shift_d = shifted;
            if (count_q == CW'(DW - 1)) begin
               done    = 1'b1;
               count_d = '0;
               state_d = IDLE;
            end else begin
               count_d = count_q + CW'(1);
            end
         end
      end

      // Latest word wins when the previous one was never accepted.
      if (done) begin
         out_d       = shifted;
         out_valid_d = 1'b1;
         overrun_set = out_valid_q && !bus.out_ready;
      end else if (out_valid_q && bus.out_ready) begin
         out_valid_d = 1'b0;
      end

      frame_err_d = frame_err_set | (frame_err_q & ~bus.err_clr);
      overrun_d   = overrun_set   | (overrun_q   & ~bus.err_clr);
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= IDLE;
         shift_q     <= '0;
         count_q     <= '0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         count_q     <= count_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
      end
   end

   assign bus.out       = out_q;
   assign bus.out_valid = out_valid_q;
   assign bus.busy      = (state_q == SHIFT);
   assign bus.frame_err = frame_err_q;
   assign bus.overrun   = overrun_q;
endmodule
